irq_arbiter: RTL and testbench
==============================

# irq_arbiter

Prioritised, nesting-aware interrupt controller between the board push-buttons and the pipelined CPU. It synchronises and debounces each raw request line and latches rising edges as pending. It arbitrates pending, unmasked lines against the interrupts already in service, then presents one request, ID and entry vector to the CPU. It tracks in-service levels through the CPU's accept (`int_ack`) and return (`eret`) handshake and drives the `IRW` in-service indicators.

## Interface
- `N_IRQ`, 3: number of request lines; higher index = higher priority.
- `DEBOUNCE_CYCLES`, 125_000: consecutive stable cycles needed to accept a level change (10 ms at 12.5 MHz); minimum 1.
- `VEC_WIDTH`, 32: vector width.
- `VEC_BASE`, 32'h0000_0100: vector of line 0.
- `VEC_STRIDE`, 32'h0000_0010: vector spacing per line.

- `clk`  in  1  CPU clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `btn_raw`  in  N_IRQ  asynchronous button levels, active-high.
- `ie`  in  1  global interrupt enable from CPU.
- `mask`  in  N_IRQ  per-line enable, 1 = enabled.
- `int_ack`  in  1  CPU has taken the presented interrupt (one-cycle pulse).
- `eret`  in  1  CPU executed return-from-interrupt (one-cycle pulse).
- `int_req`  out  1  interrupt request to CPU, registered.
- `int_id`  out  $clog2(N_IRQ)  line being requested, registered.
- `int_vec`  out  VEC_WIDTH  `VEC_BASE + int_id*VEC_STRIDE`, registered.
- `pending`  out  N_IRQ  latched, not-yet-taken events.
- `irw`  out  N_IRQ  in-service bits (to `IRW` LEDs).

## Operation
- Per line: 2-flop synchroniser, then debouncer. The debounced level flips only after the synchronised input differs from it for `DEBOUNCE_CYCLES` consecutive cycles; any agreeing cycle clears the counter.
- A rising edge of the debounced level sets `pending[i]`. Falling edges are ignored.
- `int_ack` while `int_req`=1: clears `pending[int_id]` and sets `irw[int_id]`. `int_ack` while `int_req`=0 is ignored.
- `eret`: clears the highest set bit of `irw`. `eret` with `irw`=0 is a no-op.
- Eligible lines are `pending & mask`. Request condition: `ie` and the highest eligible index is greater than the highest `irw` index, with `irw`=0 treated as −1. This gives strict priority nesting; equal or lower priority waits.
- Simultaneous events:
  - New edge on line i in the same cycle as an ack of i: `pending[i]` stays 1.
  - `eret` and `int_ack` in the same cycle: `irw_next = (irw & ~top(irw)) | onehot(int_id)`.
- Changing `mask` or clearing `ie` only gates the request. Pending bits are kept.
- Reset: `pending`, `irw`, `int_req`, `int_id`, `int_vec`-offset = 0, so `int_vec` = `VEC_BASE`. Debounced levels = 0, counters = 0, synchronisers = 0. Reset mid-debounce or mid-service discards everything.

## Timing
- `int_req`/`int_id`/`int_vec` are registered from next-state `pending`/`irw` plus current `ie`/`mask`.
- `int_req` drops in the cycle after an ack. It never shows a stale ID.
- Raw rise held stable → `pending` set `2 + DEBOUNCE_CYCLES + 1` cycles after the first sampled high. `int_req` is asserted in the same cycle `pending` shows it.
- `ie` or `mask` deassert → `int_req` low next cycle.
- `eret` → a previously blocked lower-priority `int_req` is asserted next cycle.
- A higher-priority arrival while a lower one is presented but unacked: `int_id`/`int_vec` switch to the higher line next cycle.

## Structure
- Package `irq_pkg`: `N_IRQ`, `VEC_BASE`, `VEC_STRIDE`, and a function `top_index` (highest set bit, with valid flag) shared by the arbiter and the CPU's cause logic.
- One sub-module `irq_debounce`: synchroniser + debounce counter + rising-edge pulse, instantiated N_IRQ times.
- Arbiter, pending/in-service registers and vector generation stay in `irq_arbiter`.

## Test plan
Bench uses `DEBOUNCE_CYCLES`=4.
- **Glitch rejection:** pulse `btn_raw[1]` for 3 cycles → `pending` stays 3'b000. Hold it for 10 cycles → `pending`=3'b010 at cycle 7. `int_req`=1, `int_id`=1, `int_vec`=32'h110.
- **Ack/eret:** with `mask`=3'b111, `ie`=1, `int_ack` → next cycle `pending`=0, `irw`=3'b010, `int_req`=0. `eret` → `irw`=0.
- **Nesting:**
  - Line 0 in service (`irw`=3'b001), raise line 2 → `int_req`=1, `int_id`=2, `int_vec`=32'h120. Ack → `irw`=3'b101.
  - Raise line 1 now → `int_req` stays 0. `eret` → `irw`=3'b001, and next cycle `int_id`=1.
- **Masking:** `mask`=3'b011, raise line 2 → `pending`=3'b100, `int_req`=0. Set `mask`=3'b111 → `int_req`=1 next cycle, `int_id`=2. Drop `ie` → `int_req`=0 next cycle, `pending` unchanged.
- **Simultaneous events:**
  - Same-cycle `eret` + `int_ack` with `irw`=3'b010, `int_id`=2 → `irw`=3'b100.
  - A new edge on line 2 coincident with its ack → `pending[2]`=1 afterwards.
- **Reset mid-operation:** `rst` with `pending`=3'b110 and `irw`=3'b001 → next cycle all outputs 0, `int_vec`=32'h100. A held button is re-accepted only after full sync + debounce.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared constants, types and helpers for the interrupt controller and the
// CPU's cause logic.
package irq_pkg;

  localparam int N_IRQ = 3;
  localparam int ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
  localparam int VEC_WIDTH = 32;
  localparam logic [VEC_WIDTH-1:0] VEC_BASE = 32'h0000_0100;
  localparam logic [VEC_WIDTH-1:0] VEC_STRIDE = 32'h0000_0010;

  // Highest set bit of a request/in-service vector; valid=0 means empty,
  // which the arbiter treats as priority -1.
  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] idx;
  } top_t;

  function automatic top_t top_index(input logic [N_IRQ-1:0] bits);
    top_t r;
    r.valid = 1'b0;
    r.idx   = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (bits[i]) begin
        r.valid = 1'b1;
        r.idx   = ID_W'(i);
      end
    end
    return r;
  endfunction

  function automatic logic [N_IRQ-1:0] onehot(input logic [ID_W-1:0] idx);
    return N_IRQ'(1) << idx;
  endfunction

endpackage

// File: rtl/irq_arbiter_if.sv
// CPU-facing interrupt handshake bundle. The CPU side is the master, the
// interrupt controller is the slave.
interface irq_arbiter_if;
  import irq_pkg::*;

  logic                 ie;
  logic [N_IRQ-1:0]     mask;
  logic                 int_ack;
  logic                 eret;
  logic                 int_req;
  logic [ID_W-1:0]      int_id;
  logic [VEC_WIDTH-1:0] int_vec;
  logic [N_IRQ-1:0]     pending;
  logic [N_IRQ-1:0]     irw;

  modport master (
    output ie, mask, int_ack, eret,
    input  int_req, int_id, int_vec, pending, irw
  );

  modport slave (
    input  ie, mask, int_ack, eret,
    output int_req, int_id, int_vec, pending, irw
  );
endinterface

// File: rtl/irq_debounce.sv
// One request line: 2-flop synchroniser, consecutive-cycle debounce counter
// and a registered one-cycle pulse on each debounced rising edge.
module irq_debounce #(
  parameter int DEBOUNCE_CYCLES = 125_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic rise
);
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count cycles of disagreement; flip the level when the run is long enough.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    rise_d = level_d & ~level_q;
  end

  // Synchroniser, debounce state and edge pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
    end
  end

  assign rise = rise_q;
endmodule

// File: rtl/irq_arbiter.sv
// Prioritised, nesting-aware interrupt controller: debounced button edges
// become pending events, which are arbitrated against the in-service levels
// and presented to the CPU as a registered request, ID and vector.
module irq_arbiter
  import irq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 125_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] btn_raw,
  irq_arbiter_if.slave     bus
);

  logic [N_IRQ-1:0]     rise;
  logic [N_IRQ-1:0]     pending_q, pending_d;
  logic [N_IRQ-1:0]     irw_q, irw_d;
  logic                 int_req_q, int_req_d;
  logic [ID_W-1:0]      int_id_q, int_id_d;
  logic [VEC_WIDTH-1:0] int_vec_q, int_vec_d;
  logic                 ack_take;
  top_t                 elig_top, irw_top, irw_cur_top;

  genvar gi;
  generate
    for (gi = 0; gi < N_IRQ; gi++) begin : g_line
      irq_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
        .clk    (clk),
        .rst    (rst),
        .btn_raw(btn_raw[gi]),
        .rise   (rise[gi])
      );
    end
  endgenerate

  // Next pending/in-service state, then arbitration on that next state so the
  // registered request never lags the bookkeeping.
  always_comb begin
    ack_take    = bus.int_ack & int_req_q;
    irw_cur_top = top_index(irw_q);

    // A new edge on the line being acked is ORed in after the clear, so it survives.
    pending_d = pending_q;
    if (ack_take) pending_d = pending_d & ~onehot(int_id_q);
    pending_d = pending_d | rise;

    irw_d = irw_q;
    if (bus.eret && irw_cur_top.valid) irw_d = irw_d & ~onehot(irw_cur_top.idx);
    if (ack_take) irw_d = irw_d | onehot(int_id_q);

    elig_top = top_index(pending_d & bus.mask);
    irw_top  = top_index(irw_d);

    int_req_d = bus.ie && elig_top.valid &&
                (!irw_top.valid || (elig_top.idx > irw_top.idx));
    int_id_d  = int_req_d ? elig_top.idx : '0;
    int_vec_d = VEC_BASE + VEC_WIDTH'(int_id_d) * VEC_STRIDE;
  end

  // State and registered CPU-facing outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      irw_q     <= '0;
      int_req_q <= 1'b0;
      int_id_q  <= '0;
      int_vec_q <= VEC_BASE;
    end else begin
      pending_q <= pending_d;
      irw_q     <= irw_d;
      int_req_q <= int_req_d;
      int_id_q  <= int_id_d;
      int_vec_q <= int_vec_d;
    end
  end

  assign bus.pending = pending_q;
  assign bus.irw     = irw_q;
  assign bus.int_req = int_req_q;
  assign bus.int_id  = int_id_q;
  assign bus.int_vec = int_vec_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed bench for irq_arbiter with a short debounce window.
module tb_irq_arbiter;
  import irq_pkg::*;

  logic       clk;
  logic       rst;
  logic [2:0] btn_raw;

  irq_arbiter_if bus ();

  irq_arbiter #(.DEBOUNCE_CYCLES(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(btn_raw),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  btn;
    logic        ie;
    logic [2:0]  mask;
    logic        ack;
    logic        eret;
    int          rep;
    logic [2:0]  pend;
    logic [2:0]  irw;
    logic        req;
    logic [1:0]  id;
    logic [31:0] vec;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errors = 0;

  task automatic add(input logic [2:0] btn, input logic ie, input logic [2:0] mask,
                     input logic ack, input logic eret, input int rep,
                     input logic [2:0] pend, input logic [2:0] irw, input logic req,
                     input logic [1:0] id, input logic [31:0] vec);
    vec_t v;
    v.btn = btn; v.ie = ie; v.mask = mask; v.ack = ack; v.eret = eret; v.rep = rep;
    v.pend = pend; v.irw = irw; v.req = req; v.id = id; v.vec = vec;
    tbl.push_back(v);
  endtask

  // Drive inputs at a falling edge, run rep rising edges (pulses last one
  // edge), and return at a falling edge ready for sampling.
  task automatic step(input logic [2:0] btn, input logic ie, input logic [2:0] mask,
                      input logic ack, input logic eret, input logic r, input int rep);
    btn_raw = btn; bus.ie = ie; bus.mask = mask;
    bus.int_ack = ack; bus.eret = eret; rst = r;
    for (int k = 0; k < rep; k++) begin
      @(posedge clk);
      @(negedge clk);
      bus.int_ack = 1'b0;
      bus.eret    = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [2:0] pend, input logic [2:0] irw,
                     input logic req, input logic [1:0] id, input logic [31:0] vec);
    checks += 5;
    if (bus.pending !== pend) begin
      errors++; $display("FAIL %s pending got %b exp %b", tag, bus.pending, pend);
    end
    if (bus.irw !== irw) begin
      errors++; $display("FAIL %s irw got %b exp %b", tag, bus.irw, irw);
    end
    if (bus.int_req !== req) begin
      errors++; $display("FAIL %s int_req got %b exp %b", tag, bus.int_req, req);
    end
    if (bus.int_id !== id) begin
      errors++; $display("FAIL %s int_id got %0d exp %0d", tag, bus.int_id, id);
    end
    if (bus.int_vec !== vec) begin
      errors++; $display("FAIL %s int_vec got %h exp %h", tag, bus.int_vec, vec);
    end
    $display("%s: pending=%b irw=%b req=%b id=%0d vec=%h", tag,
             bus.pending, bus.irw, bus.int_req, bus.int_id, bus.int_vec);
  endtask

  initial begin
    btn_raw = '0; bus.ie = 1'b1; bus.mask = 3'b111;
    bus.int_ack = 1'b0; bus.eret = 1'b0; rst = 1'b1;

    // btn, ie, mask, ack, eret, rep, pend, irw, req, id, vec
    // glitch rejection, then a held press
    add(3'b010, 1, 3'b111, 0, 0, 3, 3'b000, 3'b000, 0, 0, 32'h100);
    add(3'b000, 1, 3'b111, 0, 0, 8, 3'b000, 3'b000, 0, 0, 32'h100);
    add(3'b010, 1, 3'b111, 0, 0, 6, 3'b000, 3'b000, 0, 0, 32'h100);
    add(3'b010, 1, 3'b111, 0, 0, 1, 3'b010, 3'b000, 1, 1, 32'h110);
    add(3'b010, 1, 3'b111, 0, 0, 3, 3'b010, 3'b000, 1, 1, 32'h110);
    add(3'b000, 1, 3'b111, 0, 0, 8, 3'b010, 3'b000, 1, 1, 32'h110);
    // ack / eret
    add(3'b000, 1, 3'b111, 1, 0, 1, 3'b000, 3'b010, 0, 0, 32'h100);
    add(3'b000, 1, 3'b111, 0, 1, 1, 3'b000, 3'b000, 0, 0, 32'h100);
    // nesting: line 0 in service, line 2 preempts, line 1 waits
    add(3'b001, 1, 3'b111, 0, 0, 7, 3'b001, 3'b000, 1, 0, 32'h100);
    add(3'b001, 1, 3'b111, 1, 0, 1, 3'b000, 3'b001, 0, 0, 32'h100);
    add(3'b000, 1, 3'b111, 0, 0, 8, 3'b000, 3'b001, 0, 0, 32'h100);
    add(3'b100, 1, 3'b111, 0, 0, 7, 3'b100, 3'b001, 1, 2, 32'h120);
    add(3'b100, 1, 3'b111, 1, 0, 1, 3'b000, 3'b101, 0, 0, 32'h100);
    add(3'b000, 1, 3'b111, 0, 0, 8, 3'b000, 3'b101, 0, 0, 32'h100);
    add(3'b010, 1, 3'b111, 0, 0, 7, 3'b010, 3'b101, 0, 0, 32'h100);
    add(3'b010, 1, 3'b111, 0, 1, 1, 3'b010, 3'b001, 1, 1, 32'h110);
    add(3'b000, 1, 3'b111, 1, 0, 1, 3'b000, 3'b011, 0, 0, 32'h100);
    add(3'b000, 1, 3'b111, 0, 1, 1, 3'b000, 3'b001, 0, 0, 32'h100);
    add(3'b000, 1, 3'b111, 0, 1, 1, 3'b000, 3'b000, 0, 0, 32'h100);
    add(3'b000, 1, 3'b111, 0, 0, 6, 3'b000, 3'b000, 0, 0, 32'h100);
    // masking and global enable
    add(3'b100, 1, 3'b011, 0, 0, 7, 3'b100, 3'b000, 0, 0, 32'h100);
    add(3'b100, 1, 3'b111, 0, 0, 1, 3'b100, 3'b000, 1, 2, 32'h120);
    add(3'b100, 0, 3'b111, 0, 0, 1, 3'b100, 3'b000, 0, 0, 32'h100);
    add(3'b000, 1, 3'b111, 0, 0, 1, 3'b100, 3'b000, 1, 2, 32'h120);
    // same-cycle eret + ack: irw 010 with int_id 2 becomes 100
    add(3'b000, 1, 3'b011, 0, 0, 7, 3'b100, 3'b000, 0, 0, 32'h100);
    add(3'b010, 1, 3'b011, 0, 0, 7, 3'b110, 3'b000, 1, 1, 32'h110);
    add(3'b010, 1, 3'b011, 1, 0, 1, 3'b100, 3'b010, 0, 0, 32'h100);
    add(3'b000, 1, 3'b111, 0, 0, 1, 3'b100, 3'b010, 1, 2, 32'h120);
    add(3'b000, 1, 3'b111, 1, 1, 1, 3'b000, 3'b100, 0, 0, 32'h100);
    add(3'b000, 1, 3'b111, 0, 1, 1, 3'b000, 3'b000, 0, 0, 32'h100);
    add(3'b000, 1, 3'b111, 0, 0, 6, 3'b000, 3'b000, 0, 0, 32'h100);
    // new edge on line 2 coincident with its ack keeps it pending
    add(3'b100, 1, 3'b111, 0, 0, 7, 3'b100, 3'b000, 1, 2, 32'h120);
    add(3'b000, 1, 3'b111, 0, 0, 8, 3'b100, 3'b000, 1, 2, 32'h120);
    add(3'b100, 1, 3'b111, 0, 0, 6, 3'b100, 3'b000, 1, 2, 32'h120);
    add(3'b100, 1, 3'b111, 1, 0, 1, 3'b100, 3'b100, 0, 0, 32'h100);

    @(negedge clk);
    step(3'b000, 1, 3'b111, 0, 0, 1, 2);
    chk("reset", 3'b000, 3'b000, 0, 0, 32'h100);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].btn, tbl[i].ie, tbl[i].mask, tbl[i].ack, tbl[i].eret, 1'b0, tbl[i].rep);
      chk($sformatf("row%0d", i), tbl[i].pend, tbl[i].irw, tbl[i].req, tbl[i].id, tbl[i].vec);
    end

    // Reset mid-operation: build pending=110 with irw=001, then reset.
    step(3'b100, 1, 3'b111, 0, 1, 0, 1);
    chk("rs_eret", 3'b100, 3'b000, 1, 2, 32'h120);
    step(3'b101, 1, 3'b001, 0, 0, 0, 7);
    chk("rs_line0", 3'b101, 3'b000, 1, 0, 32'h100);
    step(3'b101, 1, 3'b001, 1, 0, 0, 1);
    chk("rs_ack0", 3'b100, 3'b001, 0, 0, 32'h100);
    step(3'b111, 1, 3'b001, 0, 0, 0, 7);
    chk("rs_setup", 3'b110, 3'b001, 0, 0, 32'h100);
    step(3'b111, 1, 3'b111, 0, 0, 1, 1);
    chk("rs_reset", 3'b000, 3'b000, 0, 0, 32'h100);
    step(3'b111, 1, 3'b111, 0, 0, 0, 6);
    chk("rs_wait", 3'b000, 3'b000, 0, 0, 32'h100);
    step(3'b111, 1, 3'b111, 0, 0, 0, 1);
    chk("rs_reaccept", 3'b111, 3'b000, 1, 2, 32'h120);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
